pipeline_control_irq_return_seq: RTL and testbench
==================================================

// Module: pipeline_control_irq_return_seq
// PURPOSE
//  Interrupt-return sequencer for the pipeline control unit. On iRETURN_START it restores
//  P_WORDS saved context words from the interrupt stack through a single-outstanding load
//  port, presents each word as a restore write, then pulses oFINISH. Sits beside the
//  irq call/return control and feeds the SPR/PSR restore path.
// PARAMETERS
//  P_WORDS      3   context words to restore (1..16)
//  P_ADDR_STEP  4   byte stride between saved words
//  P_IDX_W      4   width of oRESTORE_IDX, >= clog2(P_WORDS)
// PORTS
//  iCLOCK          in   1        clock
//  inRESET         in   1        async reset, active low
//  iRESET_SYNC     in   1        sync reset/flush, active high
//  iRETURN_START   in   1        start request, sampled in IDLE only
//  iSTACK_BASE     in   32       base address of saved frame, latched at start
//  oBUSY           out  1        high from the cycle after accepted start until finish
//  oLD_REQ         out  1        load request
//  oLD_ADDR        out  32       load address
//  iLD_BUSY        in   1        load port stall; request held while high
//  iLD_VALID       in   1        load data valid, one cycle
//  iLD_DATA        in   32       load data
//  oRESTORE_VALID  out  1        restore write strobe, one cycle
//  oRESTORE_IDX    out  P_IDX_W  restored word index, 0..P_WORDS-1
//  oRESTORE_DATA   out  32       restored word
//  oFINISH         out  1        one-cycle done pulse
//  oNEW_SPR_VALID  out  1        stack pointer update strobe (see CONFIGURATION)
//  oNEW_SPR        out  32       updated stack pointer
// BEHAVIOUR
//  - Async reset (inRESET low) and iRESET_SYNC: state IDLE, counter 0, base 0, all outputs 0.
//  - States: IDLE -> REQ on iRETURN_START; REQ -> WAIT when oLD_REQ && !iLD_BUSY;
//    WAIT -> REQ on iLD_VALID if idx < P_WORDS-1, else WAIT -> DONE; DONE -> IDLE.
//  - oLD_REQ = (state==REQ); oLD_ADDR = base + idx*P_ADDR_STEP, 32-bit wrap, no carry-out.
//  - Request held stable (addr constant) while iLD_BUSY high.
//  - iLD_VALID outside WAIT is ignored, no restore write.
//  - On iLD_VALID in WAIT: registered oRESTORE_VALID/IDX/DATA next cycle (1-cycle latency); idx++.
//  - oFINISH registered: high exactly one cycle, the cycle after DONE is entered, i.e.
//    coincident with the last oRESTORE_VALID.
//  - Minimum start-to-finish with zero-wait loads: 2*P_WORDS+1 cycles.
//  - iRETURN_START while not IDLE is ignored, not queued. Start same cycle as DONE->IDLE ignored.
//  - iRESET_SYNC mid-operation aborts: IDLE, no oFINISH, no further restore writes; an
//    in-flight load response after abort is ignored.
//  - oBUSY = state != IDLE.
// CONFIGURATION
//  MIST32_IRQ_RETURN_SPR_UPDATE_EN
//  - defined: oNEW_SPR_VALID pulses together with oFINISH, oNEW_SPR = base + P_WORDS*P_ADDR_STEP
//    (32-bit wrap); both reset 0, cleared on abort.
//  - undefined: oNEW_SPR_VALID and oNEW_SPR tied 0; no adder synthesised.
// TESTING
//  - P_WORDS=3, base 0x1000, zero-wait port -> addrs 0x1000/0x1004/0x1008, IDX 0,1,2, oFINISH once, cycle 7.
//  - iLD_BUSY high 4 cycles on word 1 -> oLD_REQ/oLD_ADDR 0x1004 held stable, no extra requests.
//  - iRETURN_START pulsed during WAIT -> ignored, exactly 3 restores, one oFINISH.
//  - iRESET_SYNC during WAIT of word 1 -> IDLE next cycle, late iLD_VALID gives no restore, no oFINISH.
//  - base 0xFFFFFFFC, P_WORDS=2 -> addrs 0xFFFFFFFC, 0x00000000; with macro oNEW_SPR=0x00000004.
//  - Macro undefined -> oNEW_SPR_VALID stays 0 through full sequence; inRESET low mid-run -> all outputs 0.

Source files
------------

// File: rtl/pipeline_control_irq_return_seq.sv
// pipeline_control_irq_return_seq
//   Interrupt-return sequencer. On a start request it reloads P_WORDS saved context
//   words from the interrupt stack. Each load goes out through a load port that allows
//   one outstanding request. Each returned word is presented as a registered restore
//   write, and a one-cycle finish pulse follows the last word.
//   Optional feature macro: MIST32_IRQ_RETURN_SPR_UPDATE_EN. When it is defined, the
//   block also emits the popped stack pointer together with the finish pulse.
module pipeline_control_irq_return_seq #(
  parameter int P_WORDS     = 3,
  parameter int P_ADDR_STEP = 4,
  parameter int P_IDX_W     = 4
) (
  input  logic               iCLOCK,
  input  logic               inRESET,
  input  logic               iRESET_SYNC,
  input  logic               iRETURN_START,
  input  logic [31:0]        iSTACK_BASE,
  output logic               oBUSY,
  output logic               oLD_REQ,
  output logic [31:0]        oLD_ADDR,
  input  logic               iLD_BUSY,
  input  logic               iLD_VALID,
  input  logic [31:0]        iLD_DATA,
  output logic               oRESTORE_VALID,
  output logic [P_IDX_W-1:0] oRESTORE_IDX,
  output logic [31:0]        oRESTORE_DATA,
  output logic               oFINISH,
  output logic               oNEW_SPR_VALID,
  output logic [31:0]        oNEW_SPR
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [P_IDX_W-1:0] LAST_IDX  = P_IDX_W'(P_WORDS - 1);
  localparam logic [31:0]        ADDR_STEP = 32'(P_ADDR_STEP);

  state_t               state_q, state_d;
  logic [P_IDX_W-1:0]   idx_q, idx_d;
  logic [31:0]          ld_addr_q, ld_addr_d;
  logic                 restore_valid_q, restore_valid_d;
  logic [P_IDX_W-1:0]   restore_idx_q, restore_idx_d;
  logic [31:0]          restore_data_q, restore_data_d;
  logic                 finish_q, finish_d;

`ifdef MIST32_IRQ_RETURN_SPR_UPDATE_EN
  localparam logic [31:0] FRAME_BYTES = 32'(P_WORDS * P_ADDR_STEP);
  logic [31:0] base_q, base_d;
  logic        new_spr_valid_q, new_spr_valid_d;
  logic [31:0] new_spr_q, new_spr_d;
`endif

  // Next-state and registered-output computation; sync reset aborts everything.
  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    ld_addr_d       = ld_addr_q;
    restore_valid_d = 1'b0;
    restore_idx_d   = restore_idx_q;
    restore_data_d  = restore_data_q;
    finish_d        = 1'b0;
`ifdef MIST32_IRQ_RETURN_SPR_UPDATE_EN
    base_d          = base_q;
    new_spr_valid_d = 1'b0;
    new_spr_d       = new_spr_q;
`endif
    if (iRESET_SYNC) begin
      state_d        = ST_IDLE;
      idx_d          = '0;
      ld_addr_d      = 32'h0000_0000;
      restore_idx_d  = '0;
      restore_data_d = 32'h0000_0000;
`ifdef MIST32_IRQ_RETURN_SPR_UPDATE_EN
      base_d         = 32'h0000_0000;
      new_spr_d      = 32'h0000_0000;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (iRETURN_START) begin
            state_d   = ST_REQ;
            idx_d     = '0;
            ld_addr_d = iSTACK_BASE;
`ifdef MIST32_IRQ_RETURN_SPR_UPDATE_EN
            base_d    = iSTACK_BASE;
`endif
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_REQ: begin
          // Address is a register, so it stays put while the port stalls.
          if (!iLD_BUSY) begin
            state_d = ST_WAIT;
          end else begin
            state_d = ST_REQ;
          end
        end
        ST_WAIT: begin
          if (iLD_VALID) begin
            restore_valid_d = 1'b1;
            restore_idx_d   = idx_q;
            restore_data_d  = iLD_DATA;
            if (idx_q < LAST_IDX) begin
              state_d   = ST_REQ;
              idx_d     = idx_q + P_IDX_W'(1);
              // Running sum equals base + idx*step modulo 2^32 without a multiplier.
              ld_addr_d = ld_addr_q + ADDR_STEP;
            end else begin
              // Finish is launched with the last restore so both appear together.
              state_d   = ST_DONE;
              finish_d  = 1'b1;
`ifdef MIST32_IRQ_RETURN_SPR_UPDATE_EN
              new_spr_valid_d = 1'b1;
              new_spr_d       = base_q + FRAME_BYTES;
`endif
            end
          end else begin
            state_d = ST_WAIT;
          end
        end
        ST_DONE: begin
          // A start arriving here is dropped; only IDLE accepts requests.
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state_q         <= ST_IDLE;
      idx_q           <= '0;
      ld_addr_q       <= 32'h0000_0000;
      restore_valid_q <= 1'b0;
      restore_idx_q   <= '0;
      restore_data_q  <= 32'h0000_0000;
      finish_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      ld_addr_q       <= ld_addr_d;
      restore_valid_q <= restore_valid_d;
      restore_idx_q   <= restore_idx_d;
      restore_data_q  <= restore_data_d;
      finish_q        <= finish_d;
    end
  end

`ifdef MIST32_IRQ_RETURN_SPR_UPDATE_EN
  // Latched frame base and stack pointer update registers.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      base_q          <= 32'h0000_0000;
      new_spr_valid_q <= 1'b0;
      new_spr_q       <= 32'h0000_0000;
    end else begin
      base_q          <= base_d;
      new_spr_valid_q <= new_spr_valid_d;
      new_spr_q       <= new_spr_d;
    end
  end

  assign oNEW_SPR_VALID = new_spr_valid_q;
  assign oNEW_SPR       = new_spr_q;
`else
  assign oNEW_SPR_VALID = 1'b0;
  assign oNEW_SPR       = 32'h0000_0000;
`endif

  assign oBUSY          = (state_q != ST_IDLE);
  assign oLD_REQ        = (state_q == ST_REQ);
  assign oLD_ADDR       = ld_addr_q;
  assign oRESTORE_VALID = restore_valid_q;
  assign oRESTORE_IDX   = restore_idx_q;
  assign oRESTORE_DATA  = restore_data_q;
  assign oFINISH        = finish_q;

endmodule

// File: tb/tb_pipeline_control_irq_return_seq.sv
// Directed testbench for pipeline_control_irq_return_seq (P_WORDS=3, step 4).
module tb_pipeline_control_irq_return_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sync_rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] stack_base = 32'h0;
  logic        busy_o;
  logic        ld_req;
  logic [31:0] ld_addr;
  logic        ld_busy = 1'b0;
  logic        ld_valid = 1'b0;
  logic [31:0] ld_data = 32'h0;
  logic        rs_valid;
  logic [3:0]  rs_idx;
  logic [31:0] rs_data;
  logic        finish;
  logic        spr_valid;
  logic [31:0] spr;

  pipeline_control_irq_return_seq #(.P_WORDS(3), .P_ADDR_STEP(4), .P_IDX_W(4)) dut (
    .iCLOCK(clk), .inRESET(rst_n), .iRESET_SYNC(sync_rst), .iRETURN_START(start),
    .iSTACK_BASE(stack_base), .oBUSY(busy_o), .oLD_REQ(ld_req), .oLD_ADDR(ld_addr),
    .iLD_BUSY(ld_busy), .iLD_VALID(ld_valid), .iLD_DATA(ld_data),
    .oRESTORE_VALID(rs_valid), .oRESTORE_IDX(rs_idx), .oRESTORE_DATA(rs_data),
    .oFINISH(finish), .oNEW_SPR_VALID(spr_valid), .oNEW_SPR(spr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  // Monitor / load-port model state.
  int          cyc;
  logic        pend;
  logic [31:0] pend_addr;
  int          busy_word;
  int          busy_left;
  logic [31:0] addr_log[$];
  logic [31:0] busy_addr_log[$];
  logic [3:0]  ridx_log[$];
  logic [31:0] rdata_log[$];
  int          fin_cnt, fin_cycle, spr_cnt;
  logic [31:0] spr_val;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic init_run();
    cyc = 0; pend = 1'b0; pend_addr = 32'h0; busy_word = -1; busy_left = 0;
    addr_log.delete(); busy_addr_log.delete(); ridx_log.delete(); rdata_log.delete();
    fin_cnt = 0; fin_cycle = -1; spr_cnt = 0; spr_val = 32'h0;
  endtask

  // One clock: sample outputs on the falling edge, then drive the load-port inputs.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (rs_valid) begin ridx_log.push_back(rs_idx); rdata_log.push_back(rs_data); end
    if (finish) begin fin_cnt++; fin_cycle = cyc; end
    if (spr_valid) begin spr_cnt++; spr_val = spr; end
    ld_valid = pend;
    ld_data  = pend ? mem_word(pend_addr) : 32'h0;
    pend = 1'b0;
    ld_busy = 1'b0;
    if (ld_req && addr_log.size() == busy_word && busy_left > 0) begin
      ld_busy = 1'b1;
      busy_left--;
      busy_addr_log.push_back(ld_addr);
    end
    if (ld_req && !ld_busy) begin
      addr_log.push_back(ld_addr);
      pend = 1'b1;
      pend_addr = ld_addr;
    end
  endtask

  task automatic kick(input logic [31:0] base);
    stack_base = base;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    init_run();
    rst_n = 1'b0;
    repeat (2) step();
    n_checks++;
    if ({busy_o, ld_req, ld_addr, rs_valid, rs_idx, rs_data, finish, spr_valid, spr} !== 104'h0) begin
      n_fail++; $display("FAIL reset_outputs: got %h required 0",
        {busy_o, ld_req, ld_addr, rs_valid, rs_idx, rs_data, finish, spr_valid, spr});
    end
    rst_n = 1'b1;
    step();
    n_checks++;
    if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b required 0", busy_o); end
  endtask

  task automatic test_basic();
    logic [31:0] exp_a[3];
    exp_a[0] = 32'h1000; exp_a[1] = 32'h1004; exp_a[2] = 32'h1008;
    init_run();
    kick(32'h0000_1000);
    n_checks++;
    if (busy_o !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b required 1", busy_o); end
    repeat (11) step();
    n_checks++;
    if (addr_log.size() != 3 || ridx_log.size() != 3) begin n_fail++;
      $display("FAIL basic_counts: reqs %0d restores %0d required 3/3", addr_log.size(), ridx_log.size()); end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (((i < addr_log.size()) ? addr_log[i] : 32'hDEAD_BEEF) !== exp_a[i]) begin n_fail++;
        $display("FAIL basic_addr%0d: got %h required %h", i, (i < addr_log.size()) ? addr_log[i] : 32'hDEAD_BEEF, exp_a[i]); end
      n_checks++;
      if (((i < ridx_log.size()) ? {ridx_log[i], rdata_log[i]} : 36'hF_DEAD_BEEF) !== {4'(i), mem_word(exp_a[i])}) begin n_fail++;
        $display("FAIL basic_restore%0d: got %h required %h", i,
          (i < ridx_log.size()) ? {ridx_log[i], rdata_log[i]} : 36'hF_DEAD_BEEF, {4'(i), mem_word(exp_a[i])}); end
    end
    n_checks++;
    if (fin_cnt != 1 || fin_cycle != 7) begin n_fail++;
      $display("FAIL basic_finish: count %0d cycle %0d required 1 at 7", fin_cnt, fin_cycle); end
    n_checks++;
    if (busy_o !== 1'b0) begin n_fail++; $display("FAIL basic_idle_after: got %b required 0", busy_o); end
`ifdef MIST32_IRQ_RETURN_SPR_UPDATE_EN
    n_checks++;
    if (spr_cnt != 1 || spr_val !== 32'h0000_100C) begin n_fail++;
      $display("FAIL basic_spr: count %0d value %h required 1 / 0000100c", spr_cnt, spr_val); end
`else
    n_checks++;
    if (spr_cnt != 0) begin n_fail++; $display("FAIL basic_spr_off: got %0d pulses required 0", spr_cnt); end
`endif
  endtask

  task automatic test_busy_stall();
    init_run();
    busy_word = 1; busy_left = 4;
    kick(32'h0000_1000);
    repeat (15) step();
    n_checks++;
    if (busy_addr_log.size() != 4) begin n_fail++;
      $display("FAIL stall_len: got %0d stalled cycles required 4", busy_addr_log.size()); end
    foreach (busy_addr_log[i]) begin
      n_checks++;
      if (busy_addr_log[i] !== 32'h1004) begin n_fail++;
        $display("FAIL stall_addr%0d: got %h required 00001004", i, busy_addr_log[i]); end
    end
    n_checks++;
    if (addr_log.size() != 3 || ridx_log.size() != 3) begin n_fail++;
      $display("FAIL stall_counts: reqs %0d restores %0d required 3/3", addr_log.size(), ridx_log.size()); end
    n_checks++;
    if (fin_cnt != 1 || fin_cycle != 11) begin n_fail++;
      $display("FAIL stall_finish: count %0d cycle %0d required 1 at 11", fin_cnt, fin_cycle); end
  endtask

  task automatic test_start_ignored();
    init_run();
    kick(32'h0000_3000);
    step();                       // now in WAIT for word 0
    start = 1'b1; step(); start = 1'b0;
    repeat (4) step();            // cycle 7: DONE, finish visible
    start = 1'b1; step(); start = 1'b0;   // start during DONE->IDLE
    n_checks++;
    if (busy_o !== 1'b0) begin n_fail++; $display("FAIL done_start_ignored: busy %b required 0", busy_o); end
    repeat (6) step();
    n_checks++;
    if (ridx_log.size() != 3 || fin_cnt != 1 || fin_cycle != 7) begin n_fail++;
      $display("FAIL wait_start_ignored: restores %0d finishes %0d at %0d required 3/1 at 7",
        ridx_log.size(), fin_cnt, fin_cycle); end
    n_checks++;
    if (addr_log.size() != 3) begin n_fail++; $display("FAIL ignored_reqs: got %0d required 3", addr_log.size()); end
  endtask

  task automatic test_sync_abort();
    init_run();
    kick(32'h0000_2000);
    repeat (3) step();            // cycle 4: WAIT for word 1, response queued
    ld_valid = 1'b0; pend = 1'b0;
    sync_rst = 1'b1;
    step();
    sync_rst = 1'b0;
    n_checks++;
    if (busy_o !== 1'b0 || ld_req !== 1'b0) begin n_fail++;
      $display("FAIL abort_idle: busy %b req %b required 0/0", busy_o, ld_req); end
    ld_valid = 1'b1; ld_data = 32'hBAD0_0001;   // late response
    repeat (5) step();
    n_checks++;
    if (ridx_log.size() != 1 || fin_cnt != 0 || spr_cnt != 0) begin n_fail++;
      $display("FAIL abort_quiet: restores %0d finishes %0d spr %0d required 1/0/0",
        ridx_log.size(), fin_cnt, spr_cnt); end
    n_checks++;
    if (busy_o !== 1'b0) begin n_fail++; $display("FAIL abort_stays_idle: busy %b required 0", busy_o); end
  endtask

  task automatic test_wrap();
    init_run();
    kick(32'hFFFF_FFFC);
    repeat (11) step();
    n_checks++;
    if (addr_log.size() != 3) begin n_fail++; $display("FAIL wrap_count: got %0d required 3", addr_log.size()); end
    n_checks++;
    if (addr_log.size() == 3 && {addr_log[0], addr_log[1], addr_log[2]} !== {32'hFFFF_FFFC, 32'h0, 32'h4}) begin
      n_fail++; $display("FAIL wrap_addrs: got %h %h %h required fffffffc 00000000 00000004",
        addr_log[0], addr_log[1], addr_log[2]); end
`ifdef MIST32_IRQ_RETURN_SPR_UPDATE_EN
    n_checks++;
    if (spr_val !== 32'h0000_0008) begin n_fail++; $display("FAIL wrap_spr: got %h required 00000008", spr_val); end
`endif
  endtask

  task automatic test_async_reset();
    init_run();
    kick(32'h0000_4000);
    repeat (3) step();
    #1;
    ld_valid = 1'b0; pend = 1'b0;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy_o, ld_req, ld_addr, rs_valid, rs_idx, rs_data, finish, spr_valid, spr} !== 104'h0) begin
      n_fail++; $display("FAIL async_reset_outputs: got %h required 0",
        {busy_o, ld_req, ld_addr, rs_valid, rs_idx, rs_data, finish, spr_valid, spr});
    end
    step();
    rst_n = 1'b1;
    repeat (8) step();
    n_checks++;
    if (busy_o !== 1'b0 || fin_cnt != 0 || ridx_log.size() != 1) begin n_fail++;
      $display("FAIL async_reset_after: busy %b finishes %0d restores %0d required 0/0/1",
        busy_o, fin_cnt, ridx_log.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_busy_stall();
    test_start_ignored();
    test_sync_abort();
    test_wrap();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
